// File: rtl/gp_pdet_pkg.sv
// Shared definitions for the serial receive cells: state encodings,
// parameter legality check and phase stepping helper.
package gp_pdet_pkg;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } pdet_state_e;

  localparam int         MAX_LEN    = 16;
  localparam logic [7:0] ERRCNT_MAX = 8'hFF;

  function automatic bit pdet_params_ok(input int len, input int lock_count,
                                        input int err_limit);
    return (len >= 2) && (len <= MAX_LEN) && (lock_count >= 1) && (err_limit >= 1);
  endfunction

  // Bits arrive MSB first, so the expected-bit index counts down and wraps.
  function automatic logic [3:0] phase_dec(input logic [3:0] p, input logic [3:0] last);
    return (p == 4'd0) ? last : p - 4'd1;
  endfunction

endpackage

// File: rtl/gp_pdet_window.sv
// Sliding sample window with fill counter; flags a full frame equal to the
// expected pattern on the current enabled sample.
module gp_pdet_window
  import gp_pdet_pkg::*;
#(
  parameter logic [15:0] PATTERN_DATA = 16'h0,
  parameter logic [4:0]  PATTERN_LEN  = 5'd16
) (
  input  logic CLK,
  input  logic nRST,
  input  logic IN,
  input  logic EN,
  output logic w_match
);

  localparam int LEN    = int'(PATTERN_LEN);
  localparam int FILL_W = $clog2(MAX_LEN + 1);

  // The oldest bit of w is shifted out next time, so only LEN-1 bits are stored.
  logic [LEN-2:0]    window;
  logic [LEN-1:0]    w;
  logic [FILL_W-1:0] fill;

  assign w       = {window, IN};
  assign w_match = EN && (fill >= FILL_W'(LEN - 1)) && (w == PATTERN_DATA[LEN-1:0]);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      window <= '0;
      fill   <= '0;
    end else if (EN) begin
      window <= w[LEN-2:0];
      if (fill != FILL_W'(LEN)) fill <= fill + FILL_W'(1);
    end
  end

endmodule

// File: rtl/gp_pdet.sv
// Serial pattern detector: hunts for the cyclic frame, verifies alignment,
// then tracks lock and counts bit errors until lock is lost.
module gp_pdet
  import gp_pdet_pkg::*;
#(
  parameter logic [15:0] PATTERN_DATA = 16'h0,
  parameter logic [4:0]  PATTERN_LEN  = 5'd16,
  parameter int          LOCK_COUNT   = 2,
  parameter int          ERR_LIMIT    = 2
) (
  input  logic       CLK,
  input  logic       nRST,
  input  logic       IN,
  input  logic       EN,
  output logic       LOCK,
  output logic       MATCH,
  output logic       ERR,
  output logic [3:0] PHASE,
  output logic [7:0] ERRCNT
);

  localparam logic [3:0]  LAST = 4'(PATTERN_LEN - 5'd1);
  localparam logic [15:0] LC   = 16'(LOCK_COUNT);
  localparam logic [15:0] EL   = 16'(ERR_LIMIT);

  if (!pdet_params_ok(int'(PATTERN_LEN), LOCK_COUNT, ERR_LIMIT)) begin : g_param_err
    $fatal(1, "gp_pdet: illegal PATTERN_LEN, LOCK_COUNT or ERR_LIMIT");
  end

  logic        w_match;
  pdet_state_e state, state_nx;
  logic [3:0]  phase_nx, phase_dn;
  logic [15:0] good, good_nx, bad, bad_nx;
  logic [7:0]  errcnt_nx;
  logic        match_nx, err_nx, bit_ok;

  gp_pdet_window #(
    .PATTERN_DATA (PATTERN_DATA),
    .PATTERN_LEN  (PATTERN_LEN)
  ) u_window (
    .CLK     (CLK),
    .nRST    (nRST),
    .IN      (IN),
    .EN      (EN),
    .w_match (w_match)
  );

  assign bit_ok   = (IN == PATTERN_DATA[PHASE]);
  assign phase_dn = phase_dec(PHASE, LAST);

  always_comb begin
    state_nx  = state;
    phase_nx  = PHASE;
    good_nx   = good;
    bad_nx    = bad;
    errcnt_nx = ERRCNT;
    match_nx  = 1'b0;
    err_nx    = 1'b0;
    if (EN) begin
      match_nx = w_match;
      unique case (state)
        HUNT: begin
          if (w_match) begin
            phase_nx = LAST;
            good_nx  = 16'd1;
            state_nx = (LC == 16'd1) ? LOCKED : VERIFY;
          end
        end
        VERIFY: begin
          if (!bit_ok) begin
            err_nx   = 1'b1;
            good_nx  = '0;
            state_nx = HUNT;
          end else begin
            phase_nx = phase_dn;
            if (PHASE == 4'd0) begin
              good_nx = good + 16'd1;
              if (good_nx == LC) state_nx = LOCKED;
            end
          end
        end
        LOCKED: begin
          phase_nx = phase_dn;
          if (bit_ok) begin
            bad_nx = '0;
          end else begin
            err_nx = 1'b1;
            bad_nx = bad + 16'd1;
            if (ERRCNT != ERRCNT_MAX) errcnt_nx = ERRCNT + 8'd1;
            if (bad_nx == EL) begin
              state_nx = HUNT;
              good_nx  = '0;
              bad_nx   = '0;
            end
          end
        end
        default: state_nx = HUNT;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state  <= HUNT;
      PHASE  <= '0;
      good   <= '0;
      bad    <= '0;
      ERRCNT <= '0;
      LOCK   <= 1'b0;
      MATCH  <= 1'b0;
      ERR    <= 1'b0;
    end else begin
      state  <= state_nx;
      PHASE  <= phase_nx;
      good   <= good_nx;
      bad    <= bad_nx;
      ERRCNT <= errcnt_nx;
      LOCK   <= (state_nx == LOCKED);
      MATCH  <= match_nx;
      ERR    <= err_nx;
    end
  end

endmodule

// File: tb/tb_gp_pdet.sv
// Bench for gp_pdet: frame-level reference model plus directed scenarios,
// and a loopback run against a behavioural pattern generator.
module tb_gp_pdet;

  localparam logic [15:0] PAT  = 16'h00B4;
  localparam int          LEN  = 8;
  localparam int          LC   = 2;
  localparam int          EL   = 2;
  localparam logic [15:0] PAT2 = 16'hA5C3;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic       nRST, IN, EN;
  logic       LOCK, MATCH, ERR;
  logic [3:0] PHASE;
  logic [7:0] ERRCNT;

  logic       nRST2, IN2, EN2;
  logic       LOCK2, MATCH2, ERR2;
  logic [3:0] PHASE2;
  logic [7:0] ERRCNT2;

  gp_pdet #(
    .PATTERN_DATA (PAT),
    .PATTERN_LEN  (5'd8),
    .LOCK_COUNT   (LC),
    .ERR_LIMIT    (EL)
  ) dut (
    .CLK    (CLK),
    .nRST   (nRST),
    .IN     (IN),
    .EN     (EN),
    .LOCK   (LOCK),
    .MATCH  (MATCH),
    .ERR    (ERR),
    .PHASE  (PHASE),
    .ERRCNT (ERRCNT)
  );

  gp_pdet #(
    .PATTERN_DATA (PAT2),
    .PATTERN_LEN  (5'd16),
    .LOCK_COUNT   (2),
    .ERR_LIMIT    (2)
  ) dut2 (
    .CLK    (CLK),
    .nRST   (nRST2),
    .IN     (IN2),
    .EN     (EN2),
    .LOCK   (LOCK2),
    .MATCH  (MATCH2),
    .ERR    (ERR2),
    .PHASE  (PHASE2),
    .ERRCNT (ERRCNT2)
  );

  // Behavioural generator: first bit after reset is P[0], then P[15]..P[0] forever.
  int gpos = 0;
  assign IN2 = PAT2[gpos];
  always @(posedge CLK) if (nRST2) gpos <= (gpos == 0) ? 15 : gpos - 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference model: sample history, alignment mode and error bookkeeping.
  bit hist[$];
  int m_mode, m_phase, m_good, m_bad, m_errcnt;
  bit e_match, e_err, e_lock;

  task automatic model_reset();
    hist.delete();
    m_mode = 0; m_phase = 0; m_good = 0; m_bad = 0; m_errcnt = 0;
    e_match = 0; e_err = 0; e_lock = 0;
  endtask

  task automatic model_step(input bit in, input bit en);
    int v;
    bit full, exp_bit;
    e_match = 0;
    e_err   = 0;
    if (!en) return;
    hist.push_back(in);
    if (hist.size() > LEN) void'(hist.pop_front());
    v = 0;
    foreach (hist[i]) v = (v << 1) | int'(hist[i]);
    full    = (hist.size() == LEN) && (v == int'(PAT));
    e_match = full;
    exp_bit = PAT[m_phase];
    if (m_mode == 0) begin
      if (full) begin
        m_phase = LEN - 1;
        m_good  = 1;
        m_mode  = (LC == 1) ? 2 : 1;
      end
    end else if (m_mode == 1) begin
      if (in != exp_bit) begin
        e_err  = 1;
        m_mode = 0;
        m_good = 0;
      end else begin
        if (m_phase == 0) begin
          m_good++;
          if (m_good == LC) m_mode = 2;
        end
        m_phase = (m_phase + LEN - 1) % LEN;
      end
    end else begin
      m_phase = (m_phase + LEN - 1) % LEN;
      if (in == exp_bit) m_bad = 0;
      else begin
        e_err = 1;
        m_bad++;
        if (m_errcnt < 255) m_errcnt++;
        if (m_bad == EL) begin
          m_mode = 0; m_good = 0; m_bad = 0;
        end
      end
    end
    e_lock = (m_mode == 2);
  endtask

  bit chk_on = 0;
  always @(negedge CLK) begin
    if (chk_on) begin
      check("MATCH", int'(MATCH), int'(e_match));
      check("ERR", int'(ERR), int'(e_err));
      check("LOCK", int'(LOCK), int'(e_lock));
      check("ERRCNT", int'(ERRCNT), m_errcnt);
      if (m_mode != 0) check("PHASE", int'(PHASE), m_phase);
    end
  end

  int err_seen, match_seen;

  task automatic cyc(input bit in, input bit en);
    IN = in;
    EN = en;
    @(posedge CLK);
    model_step(in, en);
    @(negedge CLK);
    err_seen   += int'(ERR);
    match_seen += int'(MATCH);
  endtask

  task automatic send_frame(input logic [7:0] flip);
    for (int i = 0; i < LEN; i++) cyc(PAT[7-i] ^ flip[7-i], 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ph, c, m2;
    nRST = 0; IN = 0; EN = 0; nRST2 = 0; EN2 = 1;
    err_seen = 0; match_seen = 0;
    model_reset();
    repeat (2) @(negedge CLK);
    check("rst_lock", int'(LOCK), 0);
    check("rst_match", int'(MATCH), 0);
    check("rst_err", int'(ERR), 0);
    check("rst_phase", int'(PHASE), 0);
    check("rst_errcnt", int'(ERRCNT), 0);
    chk_on = 1;
    nRST = 1;

    // Acquire lock with two clean frames
    for (int i = 0; i < LEN; i++) cyc(PAT[7-i], 1'b1);
    check("edge8_match", int'(MATCH), 1);
    check("edge8_lock", int'(LOCK), 0);
    for (int i = 0; i < LEN; i++) cyc(PAT[7-i], 1'b1);
    check("edge16_lock", int'(LOCK), 1);
    check("edge16_phase", int'(PHASE), 7);
    check("edge16_match", int'(MATCH), 1);
    check("acq_match_count", match_seen, 2);
    check("acq_err_count", err_seen, 0);

    // Single bit error while locked
    err_seen = 0;
    send_frame(8'h10);
    check("single_err_pulses", err_seen, 1);
    check("single_errcnt", int'(ERRCNT), 1);
    check("single_lock", int'(LOCK), 1);
    check("single_match_supp", int'(MATCH), 0);
    send_frame(8'h00);
    check("single_recover_match", int'(MATCH), 1);

    // Two consecutive errors drop lock, then relock
    err_seen = 0;
    send_frame(8'h30);
    check("loss_err_pulses", err_seen, 2);
    check("loss_lock", int'(LOCK), 0);
    check("loss_errcnt", int'(ERRCNT), 3);
    send_frame(8'h00);
    check("relock_verify_lock", int'(LOCK), 0);
    check("relock_verify_match", int'(MATCH), 1);
    send_frame(8'h00);
    check("relock_lock", int'(LOCK), 1);
    check("relock_errcnt", int'(ERRCNT), 3);

    // Enable gating mid-frame
    for (int i = 0; i < 3; i++) cyc(PAT[7-i], 1'b1);
    ph = int'(PHASE);
    check("gate_phase_before", ph, 4);
    err_seen = 0; match_seen = 0;
    for (int k = 0; k < 5; k++) cyc(bit'(k & 1), 1'b0);
    check("gate_phase_hold", int'(PHASE), ph);
    check("gate_lock_hold", int'(LOCK), 1);
    check("gate_errcnt_hold", int'(ERRCNT), 3);
    check("gate_no_err", err_seen, 0);
    check("gate_no_match", match_seen, 0);
    for (int i = 3; i < LEN; i++) cyc(PAT[7-i], 1'b1);
    send_frame(8'h00);
    check("gate_resume_err", err_seen, 0);
    check("gate_resume_match", match_seen, 2);
    check("gate_resume_lock", int'(LOCK), 1);

    // Asynchronous reset while locked
    @(posedge CLK);
    #2;
    nRST = 0;
    model_reset();
    #1;
    check("arst_lock", int'(LOCK), 0);
    check("arst_phase", int'(PHASE), 0);
    check("arst_errcnt", int'(ERRCNT), 0);
    check("arst_match", int'(MATCH), 0);
    @(negedge CLK);
    nRST = 1;
    send_frame(8'h00);
    check("arst_relock_verify", int'(LOCK), 0);
    check("arst_relock_match", int'(MATCH), 1);
    send_frame(8'h00);
    check("arst_relock_lock", int'(LOCK), 1);
    check("arst_relock_errcnt", int'(ERRCNT), 0);

    // Loopback from the behavioural generator
    chk_on = 0;
    @(negedge CLK);
    nRST2 = 1;
    c = 0;
    while (!LOCK2 && c < 48) begin
      @(negedge CLK);
      c++;
    end
    check("loop_lock", int'(LOCK2), 1);
    check("loop_lock_cycle", c, 33);
    check("loop_phase", int'(PHASE2), 15);
    m2 = 0;
    repeat (1000) begin
      @(negedge CLK);
      check("loop_err", int'(ERR2), 0);
      m2 += int'(MATCH2);
    end
    check("loop_match_count", m2, 62);
    check("loop_lock_end", int'(LOCK2), 1);
    check("loop_errcnt", int'(ERRCNT2), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
